// File: rtl/ysyx_22050710_pkg.sv
// Shared constants and types for the ysyx_22050710 fetch slice.
package ysyx_22050710_pkg;

   localparam int unsigned XLEN     = 64;
   localparam int unsigned INST_W   = 32;
   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   // Fetch unit control states.
   typedef enum logic [2:0] {
      IFU_REQ       = 3'd0,
      IFU_WAIT_RESP = 3'd1,
      IFU_OUT       = 3'd2,
      IFU_WAIT_NPC  = 3'd3,
      IFU_HALT      = 3'd4
   } ifu_state_e;

endpackage

// File: rtl/ysyx_22050710_reg.sv
// Generic load-enabled register with a synchronous, active-high reset value.
module ysyx_22050710_reg #(
   parameter int unsigned  W       = 64,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;

   // Reset wins over load; otherwise hold unless enabled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q <= RST_VAL;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/ysyx_22050710_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction per PC and
// waits for the branch unit's next PC before fetching again.
module ysyx_22050710_ifu #(
   parameter int unsigned     XLEN     = ysyx_22050710_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = ysyx_22050710_pkg::RESET_PC
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic            o_imem_req_valid,
   input  logic            i_imem_req_ready,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_resp_valid,
   input  logic [31:0]     i_imem_rdata,
   output logic            o_inst_valid,
   input  logic            i_inst_ready,
   output logic [31:0]     o_inst,
   output logic [XLEN-1:0] o_pc,
   input  logic            i_dnpc_valid,
   input  logic [XLEN-1:0] i_dnpc,
   output logic            o_misalign
);

   import ysyx_22050710_pkg::*;

   ifu_state_e      state_q;
   logic            req_valid_q;
   logic            inst_valid_q;
   logic            misalign_q;
   logic [XLEN-1:0] pc_q;
   logic            dnpc_aligned;
   logic            inst_load;
   logic            pc_load;

   assign dnpc_aligned = (i_dnpc[1:0] == 2'b00);

   // Load strobes for the PC and instruction registers, decoded from state.
   always_comb begin
      inst_load = 1'b0;
      pc_load   = 1'b0;
      case (state_q)
         IFU_REQ:       inst_load = i_imem_req_ready && i_imem_resp_valid;
         IFU_WAIT_RESP: inst_load = i_imem_resp_valid;
         IFU_WAIT_NPC:  pc_load   = i_dnpc_valid && dnpc_aligned;
         default:       ;
      endcase
   end

   ysyx_22050710_reg #(
      .W       (XLEN),
      .RST_VAL (RESET_PC)
   ) u_pc_reg (
      .clk_i (i_clk),
      .rst_i (i_rst),
      .en_i  (pc_load),
      .d_i   (i_dnpc),
      .q_o   (pc_q)
   );

   ysyx_22050710_reg #(
      .W       (INST_W),
      .RST_VAL ('0)
   ) u_inst_reg (
      .clk_i (i_clk),
      .rst_i (i_rst),
      .en_i  (inst_load),
      .d_i   (i_imem_rdata),
      .q_o   (o_inst)
   );

   // Fetch FSM; valids and misalign flag are registered alongside the state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IFU_REQ;
         req_valid_q  <= 1'b1;
         inst_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         case (state_q)
            IFU_REQ: begin
               if (i_imem_req_ready) begin
                  req_valid_q <= 1'b0;
                  // Zero-latency memory: data arrives with the acceptance.
                  if (i_imem_resp_valid) begin
                     state_q      <= IFU_OUT;
                     inst_valid_q <= 1'b1;
                  end else begin
                     state_q <= IFU_WAIT_RESP;
                  end
               end
            end
            IFU_WAIT_RESP: begin
               if (i_imem_resp_valid) begin
                  state_q      <= IFU_OUT;
                  inst_valid_q <= 1'b1;
               end
            end
            IFU_OUT: begin
               if (i_inst_ready) begin
                  state_q      <= IFU_WAIT_NPC;
                  inst_valid_q <= 1'b0;
               end
            end
            IFU_WAIT_NPC: begin
               if (i_dnpc_valid) begin
                  if (dnpc_aligned) begin
                     state_q     <= IFU_REQ;
                     req_valid_q <= 1'b1;
                  end else begin
                     state_q    <= IFU_HALT;
                     misalign_q <= 1'b1;
                  end
               end
            end
            IFU_HALT: begin
               state_q      <= IFU_HALT;
               req_valid_q  <= 1'b0;
               inst_valid_q <= 1'b0;
            end
            default: begin
               state_q      <= IFU_REQ;
               req_valid_q  <= 1'b1;
               inst_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_imem_req_valid = req_valid_q;
   assign o_inst_valid     = inst_valid_q;
   assign o_misalign       = misalign_q;
   assign o_pc             = pc_q;
   assign o_imem_addr      = pc_q;

`ifndef SYNTHESIS
   // Protocol checks: stray responses or next-PCs are ignored by the FSM.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         assert (!(i_imem_resp_valid && (state_q != IFU_WAIT_RESP) &&
                   !(state_q == IFU_REQ && i_imem_req_ready)))
            else $warning("ifu: imem response outside an open fetch ignored");
         assert (!(i_dnpc_valid && (state_q != IFU_WAIT_NPC)))
            else $warning("ifu: dnpc_valid outside WAIT_NPC ignored");
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_22050710_ifu.sv
// Directed bench for ysyx_22050710_ifu: inputs change and outputs are sampled
// on the falling clock edge, expected values are hand-computed constants.
module tb_ysyx_22050710_ifu;

   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] addr;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] pc;
   logic        dnpc_valid;
   logic [63:0] dnpc;
   logic        misalign;

   int unsigned n_cmp;
   int unsigned n_err;

   ysyx_22050710_ifu #(
      .XLEN     (64),
      .RESET_PC (RST_PC)
   ) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .o_imem_req_valid  (req_valid),
      .i_imem_req_ready  (req_ready),
      .o_imem_addr       (addr),
      .i_imem_resp_valid (resp_valid),
      .i_imem_rdata      (rdata),
      .o_inst_valid      (inst_valid),
      .i_inst_ready      (inst_ready),
      .o_inst            (inst),
      .o_pc              (pc),
      .i_dnpc_valid      (dnpc_valid),
      .i_dnpc            (dnpc),
      .o_misalign        (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drives REQ -> WAIT_RESP -> OUT -> WAIT_NPC with 1-cycle memory latency.
   task automatic fetch_to_npc(input logic [31:0] rd, input logic [63:0] pc_exp);
      chk("req_valid", {63'd0, req_valid}, 64'd1);
      chk("req_addr", addr, pc_exp);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      chk("wresp_req_valid", {63'd0, req_valid}, 64'd0);
      chk("wresp_inst_valid", {63'd0, inst_valid}, 64'd0);
      resp_valid = 1'b1;
      rdata      = rd;
      tick();
      resp_valid = 1'b0;
      chk("out_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("out_inst", {32'd0, inst}, {32'd0, rd});
      chk("out_pc", pc, pc_exp);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("npc_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("npc_req_valid", {63'd0, req_valid}, 64'd0);
   endtask

   task automatic give_npc(input logic [63:0] np, input logic [63:0] addr_exp);
      dnpc_valid = 1'b1;
      dnpc       = np;
      tick();
      dnpc_valid = 1'b0;
      chk("redir_req_valid", {63'd0, req_valid}, 64'd1);
      chk("redir_addr", addr, addr_exp);
      chk("redir_misalign", {63'd0, misalign}, 64'd0);
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      rst        = 1'b1;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      rdata      = '0;
      inst_ready = 1'b0;
      dnpc_valid = 1'b0;
      dnpc       = '0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_req_valid", {63'd0, req_valid}, 64'd1);
      chk("rst_addr", addr, RST_PC);
      chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("rst_inst", {32'd0, inst}, 64'd0);
      chk("rst_misalign", {63'd0, misalign}, 64'd0);

      // Sequential fetch
      fetch_to_npc(32'h0000_0013, RST_PC);
      give_npc(64'h0000_0000_8000_0004, 64'h0000_0000_8000_0004);

      // Request backpressure: three stalled cycles, then zero-latency response
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_req_valid", {63'd0, req_valid}, 64'd1);
         chk("bp_addr", addr, 64'h0000_0000_8000_0004);
         chk("bp_inst_valid", {63'd0, inst_valid}, 64'd0);
      end
      req_ready  = 1'b1;
      resp_valid = 1'b1;
      rdata      = 32'hDEAD_BEEF;
      tick();
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      rdata      = 32'h1234_5678;
      chk("zl_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("zl_req_valid", {63'd0, req_valid}, 64'd0);
      chk("zl_inst", {32'd0, inst}, 64'h0000_0000_DEAD_BEEF);

      // Decode backpressure: five stalled cycles, then one handshake
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("dbp_inst_valid", {63'd0, inst_valid}, 64'd1);
         chk("dbp_inst", {32'd0, inst}, 64'h0000_0000_DEAD_BEEF);
         chk("dbp_pc", pc, 64'h0000_0000_8000_0004);
      end
      inst_ready = 1'b1;
      tick();
      chk("hs_inst_valid", {63'd0, inst_valid}, 64'd0);
      tick();
      inst_ready = 1'b0;
      chk("hs_once_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("hs_once_req_valid", {63'd0, req_valid}, 64'd0);

      // Branch redirects including top-of-address-space target
      give_npc(64'h0000_0000_8000_1000, 64'h0000_0000_8000_1000);
      fetch_to_npc(32'h0010_0093, 64'h0000_0000_8000_1000);
      give_npc(64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
      fetch_to_npc(32'h0000_006F, 64'hFFFF_FFFF_FFFF_FFFC);
      give_npc(64'h0, 64'h0);

      // Misaligned target halts fetch
      fetch_to_npc(32'h0000_0013, 64'h0);
      dnpc_valid = 1'b1;
      dnpc       = 64'h0000_0000_8000_0002;
      tick();
      dnpc_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_ready = 1'b1;
         chk("halt_misalign", {63'd0, misalign}, 64'd1);
         chk("halt_req_valid", {63'd0, req_valid}, 64'd0);
         chk("halt_inst_valid", {63'd0, inst_valid}, 64'd0);
         chk("halt_pc", pc, 64'h0);
         tick();
      end
      req_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("unhalt_misalign", {63'd0, misalign}, 64'd0);
      chk("unhalt_req_valid", {63'd0, req_valid}, 64'd1);
      chk("unhalt_addr", addr, RST_PC);

      // Reset while waiting for a response
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      chk("mid_wresp_req_valid", {63'd0, req_valid}, 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_wresp_req_valid", {63'd0, req_valid}, 64'd1);
      chk("rst_wresp_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("rst_wresp_pc", pc, RST_PC);

      // Reset while presenting an instruction
      fetch_to_npc(32'h0000_0513, RST_PC);
      give_npc(64'h0000_0000_8000_0010, 64'h0000_0000_8000_0010);
      req_ready = 1'b1;
      tick();
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      rdata      = 32'h0050_0593;
      tick();
      resp_valid = 1'b0;
      chk("mid_out_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("mid_out_pc", pc, 64'h0000_0000_8000_0010);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_out_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("rst_out_req_valid", {63'd0, req_valid}, 64'd1);
      chk("rst_out_pc", pc, RST_PC);
      chk("rst_out_inst", {32'd0, inst}, 64'd0);

      // Spurious next-PC while requesting is ignored
      dnpc_valid = 1'b1;
      dnpc       = 64'h0000_0000_8000_0040;
      tick();
      dnpc_valid = 1'b0;
      chk("spur_addr", addr, RST_PC);
      chk("spur_req_valid", {63'd0, req_valid}, 64'd1);

      // Normal operation resumes afterwards
      fetch_to_npc(32'h0000_0073, RST_PC);
      give_npc(64'h0000_0000_8000_0004, 64'h0000_0000_8000_0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
